byte_mem_ctrl: RTL and testbench
================================

Name: byte_mem_ctrl

Overview:
Parametrised word-wide memory with per-byte write enables, a fixed multi-cycle access latency, and a valid/ready request handshake. It returns a one-cycle response strobe, which serves as the LC-3b memory-ready (R) signal.
It replaces the separate high and low byte banks with a single controller that the datapath's MAR/MDR logic drives.
On reset it clears the whole array sequentially, one word per cycle, before accepting any request.

Parameters:
ADDR_W, 8, word-address width; DEPTH = 2**ADDR_W words
DATA_W, 16, word width; must be a multiple of 8; NB = DATA_W/8 byte lanes
LATENCY, 4, cycles from request acceptance to response; legal range 1..15
CLEAR_ON_RESET, 1, 1 = zero the array after reset; 0 = skip directly to IDLE

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request this cycle
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
req_be  in  NB  byte-lane write enables; bit k covers bits [8k+7:8k]
rsp_valid  out  1  one-cycle response strobe (memory ready)
rsp_rdata  out  DATA_W  read data, or post-write word contents on a write
clear_done  out  1  high once the reset clear has completed

Behaviour:
- Reset:
  - Synchronous: reset==0 sampled at a rising edge takes effect on that edge and wins over every other event.
  - Values while in reset: state=CLEAR (or IDLE if CLEAR_ON_RESET=0), clr_ptr=0, cnt=0, req_ready=0, rsp_valid=0, rsp_rdata=0, clear_done=0 (1 if CLEAR_ON_RESET=0).
- States:
  - CLEAR:
    - Each edge writes 0 to mem[clr_ptr] and increments clr_ptr.
    - On the edge that writes mem[DEPTH-1], go to IDLE and set clear_done=1.
    - Total duration is exactly DEPTH cycles.
    - req_ready=0 throughout; req_valid is ignored.
  - IDLE:
    - req_ready=1.
    - On an edge with req_valid && req_ready, latch addr/write/wdata/be, set cnt=LATENCY-1, go to BUSY.
  - BUSY:
    - req_ready=0.
    - While cnt!=0, decrement cnt each edge.
    - On the edge with cnt==0:
      - Perform the access.
      - Write: update only the lanes with be=1.
      - rsp_rdata <= resulting word; for a read, this is the stored word.
      - rsp_valid <= 1; go to IDLE.
- Latency and strobe:
  - A request accepted at edge T0 produces rsp_valid=1 in the cycle after edge T0+LATENCY.
  - rsp_valid lasts exactly one cycle.
  - req_ready is also 1 in that cycle, so a back-to-back request is accepted on edge T0+LATENCY+1.
  - Peak throughput is one access per LATENCY+1 cycles.
- Output hold: rsp_rdata holds its value until the next response or reset.
- Write with be==0: memory is unchanged; the response still pulses and returns the current word.
- Inputs during BUSY: req_* inputs are not sampled; the latched copies are used, so changing inputs mid-access has no effect.
- Reset mid-access: the pending access is aborted, no write occurs, no rsp_valid is produced, and the CLEAR sequence restarts.
- Addressing: all ADDR_W bits are decoded; no aliasing; addresses 0 and DEPTH-1 are fully usable.
- Reads of the array are synchronous; there is no combinational path from req_* to rsp_*.

Test Plan (ADDR_W=8, DATA_W=16, LATENCY=4, CLEAR_ON_RESET=1):
1. Hold reset low 2 cycles, then release.
   -> req_ready=0 and clear_done=0 for 256 cycles; clear_done=1 and req_ready=1 from cycle 257.
   -> A subsequent read of 0x55 returns 0x0000.
2. Write addr 0x08, data 0x1234, be=2'b11, accepted at edge T0.
   -> Single rsp_valid pulse after edge T0+4 with rsp_rdata=0x1234.
   -> A read of 0x08 returns 0x1234.
3. Byte-lane writes to 0x08 (starting from 0x1234):
   -> data 0xABCD, be=10 gives rsp_rdata=0xAB34.
   -> Then data 0x00EF, be=01 gives 0xABEF.
   -> Then be=00 leaves 0xABEF, and rsp_valid still pulses.
4. Back-to-back reads: hold req_valid=1 with reads of 0x08 then 0x09 (0x09 preloaded with 0x0002).
   -> Second request accepted on the edge after the first rsp_valid.
   -> Responses 0xABEF and 0x0002, with strobes 5 cycles apart.
5. Reset mid-op: accept a write of 0xBEEF to 0x10, drive reset low 2 cycles later.
   -> No rsp_valid; CLEAR restarts.
   -> After clear_done, a read of 0x10 returns 0x0000.
6. Extremes and clear gating:
   -> Write 0x5A5A to 0xFF and 0xA5A5 to 0x00; read back both correctly.
   -> A write request held during CLEAR is not accepted until req_ready=1, then completes normally.

Source files
------------

// File: rtl/byte_mem_ctrl.sv
// Word memory with byte-lane writes and clear-on-reset; response strobe LATENCY+1 cycles after accept.
// Backpressure: req_ready only in IDLE, so one access is in flight and none during the reset clear.
module byte_mem_ctrl #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 16,
  parameter int LATENCY        = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  clear_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_BUSY} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [3:0]          cnt;
  logic                lat_write;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [NB-1:0]       lat_be;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   cur_word, new_word;
  logic                accept, access;

  always_ff @(posedge clk) begin
    if (!reset) state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    access    = 1'b0;
    case (state)
      S_CLEAR: if (clr_ptr == '1) state_nxt = S_IDLE;
      S_IDLE: begin
        req_ready = reset;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: if (cnt == '0) begin
        access    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read-modify-write merge: unselected lanes keep the stored bytes.
  always_comb begin
    cur_word = mem[lat_addr];
    new_word = cur_word;
    if (lat_write) begin
      for (int k = 0; k < NB; k++) begin
        if (lat_be[k]) new_word[8*k +: 8] = lat_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      clr_ptr    <= '0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      clear_done <= (CLEAR_ON_RESET == 0);
    end else begin
      rsp_valid <= 1'b0;
      if (state == S_CLEAR) begin
        clr_ptr <= clr_ptr + 1'b1;
        if (clr_ptr == '1) clear_done <= 1'b1;
      end
      if (accept)                          cnt <= LAT_M1;
      else if (state == S_BUSY && cnt != '0) cnt <= cnt - 1'b1;
      if (access) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= new_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && accept) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

  // Gated by reset so an access aborted by reset never reaches the array.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == S_CLEAR)          mem[clr_ptr]  <= '0;
      else if (access && lat_write)  mem[lat_addr] <= new_word;
    end
  end

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Directed bench for byte_mem_ctrl: clear timing, byte lanes, back-to-back, reset abort, extremes.
module tb_byte_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        clear_done;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  byte_mem_ctrl #(.ADDR_W(8), .DATA_W(16), .LATENCY(4), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .clear_done(clear_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    req_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Counts not-ready cycles from now until req_ready rises (bounded).
  task automatic wait_clear(output int nrdy, output logic early, output logic saw_rsp);
    nrdy = 0; early = 1'b0; saw_rsp = 1'b0;
    while (!req_ready && nrdy < 400) begin
      nrdy++;
      if (clear_done) early = 1'b1;
      if (rsp_valid) saw_rsp = 1'b1;
      tick();
    end
  endtask

  // Drives one request, scrambles inputs while busy, returns data, latency and next-cycle strobe.
  task automatic issue(input logic w, input logic [7:0] a, input logic [15:0] d, input logic [1:0] be,
                       output logic [15:0] rd, output int lat, output logic after);
    int n = 0;
    while (!req_ready && n < 400) begin tick(); n++; end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    tick();
    req_valid = 1'b0; req_write = ~w; req_addr = ~a; req_wdata = ~d; req_be = ~be;
    lat = -1; rd = 'x; after = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (rsp_valid) begin lat = i; rd = rsp_rdata; break; end
    end
    if (lat > 0) begin tick(); after = rsp_valid; end
  endtask

  task automatic test_reset();
    int nrdy, lat; logic early, saw, after; logic [15:0] rd;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h55; req_wdata = 16'hFFFF; req_be = 2'b11;
    apply_reset();
    checks++; if (req_ready !== 1'b0) $display("FAIL rst_ready: got %b expected 0", req_ready); else passed++;
    checks++; if (clear_done !== 1'b0) $display("FAIL rst_clear_done: got %b expected 0", clear_done); else passed++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); else passed++;
    checks++; if (rsp_rdata !== 16'h0000) $display("FAIL rst_rsp_rdata: got %h expected 0000", rsp_rdata); else passed++;
    req_valid = 1'b0;
    wait_clear(nrdy, early, saw);
    checks++; if (nrdy !== 256) $display("FAIL clear_cycles: got %0d expected 256", nrdy); else passed++;
    checks++; if (early !== 1'b0) $display("FAIL clear_done_early: got %b expected 0", early); else passed++;
    checks++; if (clear_done !== 1'b1) $display("FAIL clear_done_set: got %b expected 1", clear_done); else passed++;
    issue(1'b0, 8'h55, 16'h0, 2'b00, rd, lat, after);
    checks++; if (rd !== 16'h0000) $display("FAIL clear_read55: got %h expected 0000", rd); else passed++;
    checks++; if (lat !== 4) $display("FAIL rd_latency: got %0d expected 4", lat); else passed++;
  endtask

  task automatic test_write();
    int lat; logic after; logic [15:0] rd;
    issue(1'b1, 8'h08, 16'h1234, 2'b11, rd, lat, after);
    checks++; if (lat !== 4) $display("FAIL wr_latency: got %0d expected 4", lat); else passed++;
    checks++; if (rd !== 16'h1234) $display("FAIL wr_rdata: got %h expected 1234", rd); else passed++;
    checks++; if (after !== 1'b0) $display("FAIL wr_pulse_width: got %b expected 0", after); else passed++;
    tick(); tick();
    checks++; if (rsp_rdata !== 16'h1234) $display("FAIL rdata_hold: got %h expected 1234", rsp_rdata); else passed++;
    issue(1'b0, 8'h08, 16'h0, 2'b00, rd, lat, after);
    checks++; if (rd !== 16'h1234) $display("FAIL rd08: got %h expected 1234", rd); else passed++;
  endtask

  task automatic test_byte_lanes();
    int lat; logic after; logic [15:0] rd;
    issue(1'b1, 8'h08, 16'hABCD, 2'b10, rd, lat, after);
    checks++; if (rd !== 16'hAB34) $display("FAIL be_hi: got %h expected ab34", rd); else passed++;
    issue(1'b1, 8'h08, 16'h00EF, 2'b01, rd, lat, after);
    checks++; if (rd !== 16'hABEF) $display("FAIL be_lo: got %h expected abef", rd); else passed++;
    issue(1'b1, 8'h08, 16'h1111, 2'b00, rd, lat, after);
    checks++; if (rd !== 16'hABEF) $display("FAIL be_none: got %h expected abef", rd); else passed++;
    checks++; if (lat !== 4) $display("FAIL be_none_strobe: got %0d expected 4", lat); else passed++;
    issue(1'b0, 8'h08, 16'h0, 2'b00, rd, lat, after);
    checks++; if (rd !== 16'hABEF) $display("FAIL be_readback: got %h expected abef", rd); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat, t1 = -1, t2 = -1; logic after, rdy1 = 1'b0; logic [15:0] rd, d1 = 'x, d2 = 'x;
    issue(1'b1, 8'h09, 16'h0002, 2'b11, rd, lat, after);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h08; req_be = 2'b00;
    tick();
    req_addr = 8'h09;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (rsp_valid) begin
        if (t1 < 0) begin t1 = i; d1 = rsp_rdata; rdy1 = req_ready; end
        else begin t2 = i; d2 = rsp_rdata; req_valid = 1'b0; break; end
      end
    end
    req_valid = 1'b0;
    checks++; if (t1 !== 4) $display("FAIL b2b_first_time: got %0d expected 4", t1); else passed++;
    checks++; if (d1 !== 16'hABEF) $display("FAIL b2b_first_data: got %h expected abef", d1); else passed++;
    checks++; if (rdy1 !== 1'b1) $display("FAIL b2b_ready_on_rsp: got %b expected 1", rdy1); else passed++;
    checks++; if (t2 - t1 !== 5) $display("FAIL b2b_gap: got %0d expected 5", t2 - t1); else passed++;
    checks++; if (d2 !== 16'h0002) $display("FAIL b2b_second_data: got %h expected 0002", d2); else passed++;
  endtask

  task automatic test_reset_mid_op();
    int nrdy, lat; logic early, saw, after, seen = 1'b0; logic [15:0] rd;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = 16'hBEEF; req_be = 2'b11;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin tick(); if (rsp_valid) seen = 1'b1; end
    checks++; if (clear_done !== 1'b0) $display("FAIL midop_clear_done: got %b expected 0", clear_done); else passed++;
    checks++; if (rsp_rdata !== 16'h0000) $display("FAIL midop_rdata_rst: got %h expected 0000", rsp_rdata); else passed++;
    reset = 1'b1;
    wait_clear(nrdy, early, saw);
    checks++; if ((seen | saw) !== 1'b0) $display("FAIL midop_no_rsp: got %b expected 0", seen | saw); else passed++;
    checks++; if (nrdy !== 256) $display("FAIL midop_clear_cycles: got %0d expected 256", nrdy); else passed++;
    issue(1'b0, 8'h10, 16'h0, 2'b00, rd, lat, after);
    checks++; if (rd !== 16'h0000) $display("FAIL midop_read10: got %h expected 0000", rd); else passed++;
  endtask

  task automatic test_extremes();
    int lat; logic after; logic [15:0] rd;
    issue(1'b1, 8'hFF, 16'h5A5A, 2'b11, rd, lat, after);
    issue(1'b1, 8'h00, 16'hA5A5, 2'b11, rd, lat, after);
    issue(1'b0, 8'hFF, 16'h0, 2'b00, rd, lat, after);
    checks++; if (rd !== 16'h5A5A) $display("FAIL ext_readFF: got %h expected 5a5a", rd); else passed++;
    issue(1'b0, 8'h00, 16'h0, 2'b00, rd, lat, after);
    checks++; if (rd !== 16'hA5A5) $display("FAIL ext_read00: got %h expected a5a5", rd); else passed++;
  endtask

  task automatic test_clear_gating();
    int nrdy, lat = -1; logic early, saw, after; logic [15:0] rd = 'x;
    apply_reset();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h33; req_wdata = 16'h7777; req_be = 2'b11;
    wait_clear(nrdy, early, saw);
    checks++; if (saw !== 1'b0) $display("FAIL gate_rsp_in_clear: got %b expected 0", saw); else passed++;
    checks++; if (nrdy !== 256) $display("FAIL gate_clear_cycles: got %0d expected 256", nrdy); else passed++;
    tick();
    req_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (rsp_valid) begin lat = i; rd = rsp_rdata; break; end
    end
    checks++; if (lat !== 4) $display("FAIL gate_latency: got %0d expected 4", lat); else passed++;
    checks++; if (rd !== 16'h7777) $display("FAIL gate_rdata: got %h expected 7777", rd); else passed++;
    issue(1'b0, 8'h33, 16'h0, 2'b00, rd, lat, after);
    checks++; if (rd !== 16'h7777) $display("FAIL gate_readback: got %h expected 7777", rd); else passed++;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    test_reset();
    test_write();
    test_byte_lanes();
    test_back_to_back();
    test_reset_mid_op();
    test_extremes();
    test_clear_gating();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
